// File: rtl/bus_cycle_seq_if.sv
// rtl/bus_cycle_seq_if.sv - request/bus signal bundle for bus_cycle_seq
//
// Groups the cycle request handshake, the multiplexed AD bus and the
// bus-control/status lines so they travel as one port.
//   master : the requester side (drives cycle_req..hold, observes results)
//   slave  : the sequencer side (bus_cycle_seq)

interface bus_cycle_seq_if;
    // request side
    logic        cycle_req;
    logic [2:0]  cycle_type;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  ad_in;
    logic        ready;
    logic        hold;
    // sequencer outputs
    logic        req_ack;
    logic [7:0]  a_hi;
    logic [7:0]  ad_out;
    logic        ad_oe;
    logic        bus_oe;
    logic        ale;
    logic        rd_n;
    logic        wr_n;
    logic        inta_n;
    logic        io_m;
    logic        s1;
    logic        s0;
    logic [7:0]  rdata;
    logic        cycle_done;
    logic        hlda;
    logic [2:0]  tstate;

    modport master (
        output cycle_req, cycle_type, addr, wdata, ad_in, ready, hold,
        input  req_ack, a_hi, ad_out, ad_oe, bus_oe, ale, rd_n, wr_n, inta_n,
               io_m, s1, s0, rdata, cycle_done, hlda, tstate
    );

    modport slave (
        input  cycle_req, cycle_type, addr, wdata, ad_in, ready, hold,
        output req_ack, a_hi, ad_out, ad_oe, bus_oe, ale, rd_n, wr_n, inta_n,
               io_m, s1, s0, rdata, cycle_done, hlda, tstate
    );
endinterface

// File: rtl/bus_cycle_seq.sv
// rtl/bus_cycle_seq.sv - 8085-style bus cycle T-state sequencer
//
// Runs one bus cycle (fetch, mem rd/wr, IO rd/wr, INTA) per accepted request
// through TI/T1/T2/TW/T3/T4 and yields the bus to a DMA master in THOLD.
// Ports:
//   phi1  - sole clock, rising edge
//   reset - synchronous, active-high
//   bus   - bus_cycle_seq_if.slave: request handshake, AD bus, strobes,
//           status, hold/hlda, captured read data, tstate
// Configuration macro: BUS_WAIT_STATE_EN
//   defined   - ready is sampled in T2/TW and low ready inserts TW states
//   undefined - ready is ignored, T2 always proceeds to T3

module bus_cycle_seq (
    input  logic           phi1,
    input  logic           reset,
    bus_cycle_seq_if.slave bus
);

    // Encoding equals the externally visible tstate code.
    typedef enum logic [2:0] {
        S_TI    = 3'd0,
        S_T1    = 3'd1,
        S_T2    = 3'd2,
        S_T3    = 3'd3,
        S_T4    = 3'd4,
        S_TW    = 3'd5,
        S_THOLD = 3'd6
    } state_t;

    localparam logic [2:0] TY_FETCH = 3'd0;
    localparam logic [2:0] TY_MEMRD = 3'd1;
    localparam logic [2:0] TY_MEMWR = 3'd2;
    localparam logic [2:0] TY_IORD  = 3'd3;
    localparam logic [2:0] TY_IOWR  = 3'd4;
    localparam logic [2:0] TY_INTA  = 3'd5;

    function automatic logic is_write(input logic [2:0] t);
        return (t == TY_MEMWR) || (t == TY_IOWR);
    endfunction

    // Fetch and INTA carry an extra T4 after T3.
    function automatic logic is_long(input logic [2:0] t);
        return (t == TY_FETCH) || (t == TY_INTA);
    endfunction

    // {io_m, s1, s0}
    function automatic logic [2:0] status_of(input logic [2:0] t);
        case (t)
            TY_FETCH: return 3'b011;
            TY_MEMRD: return 3'b010;
            TY_MEMWR: return 3'b001;
            TY_IORD:  return 3'b110;
            TY_IOWR:  return 3'b101;
            TY_INTA:  return 3'b111;
            default:  return 3'b000;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  type_q, type_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic [7:0]  rdata_q, rdata_d;

    logic        ale_q, ale_d;
    logic        rd_n_q, rd_n_d;
    logic        wr_n_q, wr_n_d;
    logic        inta_n_q, inta_n_d;
    logic [2:0]  stat_q, stat_d;
    logic        ad_oe_q, ad_oe_d;
    logic        bus_oe_q, bus_oe_d;
    logic        hlda_q, hlda_d;
    logic [7:0]  a_hi_q, a_hi_d;
    logic [7:0]  ad_out_q, ad_out_d;
    logic        cycle_done_q, cycle_done_d;

    logic        is_final;
    logic        accept;
    logic        in_bus;
    logic        mid;

`ifndef BUS_WAIT_STATE_EN
    logic unused_ready;
    assign unused_ready = bus.ready;
`endif

    // Next state and latched request fields.
    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        is_final = ((state_q == S_T3) && !is_long(type_q)) || (state_q == S_T4);
        // A new request may overlap the final T-state so cycles run back-to-back.
        accept = !reset && bus.cycle_req && (bus.cycle_type <= 3'd5) && !bus.hold &&
                 ((state_q == S_TI) || is_final);

        if ((state_q == S_T3) && !is_write(type_q)) begin
            rdata_d = bus.ad_in;
        end

        case (state_q)
            S_T1: state_d = S_T2;
`ifdef BUS_WAIT_STATE_EN
            S_T2, S_TW: state_d = bus.ready ? S_T3 : S_TW;
`else
            S_T2, S_TW: state_d = S_T3;
`endif
            S_THOLD: state_d = bus.hold ? S_THOLD : S_TI;
            default: begin
                if (state_q == S_T3 && is_long(type_q)) begin
                    state_d = S_T4;
                end else if (bus.hold) begin
                    state_d = S_THOLD;
                end else if (accept) begin
                    state_d = S_T1;
                end else begin
                    state_d = S_TI;
                end
            end
        endcase

        if (accept) begin
            type_d  = bus.cycle_type;
            addr_d  = bus.addr;
            wdata_d = bus.wdata;
        end
    end

    // Output decode of the state being entered, so every output is a flop.
    always_comb begin
        ale_d        = 1'b0;
        rd_n_d       = 1'b1;
        wr_n_d       = 1'b1;
        inta_n_d     = 1'b1;
        stat_d       = 3'b000;
        ad_oe_d      = 1'b0;
        bus_oe_d     = 1'b1;
        hlda_d       = 1'b0;
        a_hi_d       = 8'h00;
        ad_out_d     = 8'h00;
        cycle_done_d = 1'b0;

        in_bus = (state_d == S_T1) || (state_d == S_T2) || (state_d == S_TW) ||
                 (state_d == S_T3) || (state_d == S_T4);
        mid    = (state_d == S_T2) || (state_d == S_TW) || (state_d == S_T3);

        if (in_bus) begin
            stat_d = status_of(type_d);
            a_hi_d = addr_d[15:8];
        end
        if (state_d == S_T1) begin
            ale_d    = 1'b1;
            ad_oe_d  = 1'b1;
            ad_out_d = addr_d[7:0];
        end
        if (mid) begin
            if (is_write(type_d)) begin
                wr_n_d   = 1'b0;
                ad_oe_d  = 1'b1;
                ad_out_d = wdata_d;
            end else if (type_d == TY_INTA) begin
                inta_n_d = 1'b0;
            end else begin
                rd_n_d = 1'b0;
            end
        end
        cycle_done_d = ((state_d == S_T3) && !is_long(type_d)) || (state_d == S_T4);
        if (state_d == S_THOLD) begin
            hlda_d   = 1'b1;
            bus_oe_d = 1'b0;
        end
    end

    always_ff @(posedge phi1) begin
        if (reset) begin
            state_q      <= S_TI;
            type_q       <= 3'd0;
            addr_q       <= 16'h0000;
            wdata_q      <= 8'h00;
            rdata_q      <= 8'h00;
            ale_q        <= 1'b0;
            rd_n_q       <= 1'b1;
            wr_n_q       <= 1'b1;
            inta_n_q     <= 1'b1;
            stat_q       <= 3'b000;
            ad_oe_q      <= 1'b0;
            bus_oe_q     <= 1'b1;
            hlda_q       <= 1'b0;
            a_hi_q       <= 8'h00;
            ad_out_q     <= 8'h00;
            cycle_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            type_q       <= type_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            ale_q        <= ale_d;
            rd_n_q       <= rd_n_d;
            wr_n_q       <= wr_n_d;
            inta_n_q     <= inta_n_d;
            stat_q       <= stat_d;
            ad_oe_q      <= ad_oe_d;
            bus_oe_q     <= bus_oe_d;
            hlda_q       <= hlda_d;
            a_hi_q       <= a_hi_d;
            ad_out_q     <= ad_out_d;
            cycle_done_q <= cycle_done_d;
        end
    end

    // req_ack must answer in the same cycle the request is seen.
    assign bus.req_ack    = accept;
    assign bus.tstate     = state_q;
    assign bus.ale        = ale_q;
    assign bus.rd_n       = rd_n_q;
    assign bus.wr_n       = wr_n_q;
    assign bus.inta_n     = inta_n_q;
    assign bus.io_m       = stat_q[2];
    assign bus.s1         = stat_q[1];
    assign bus.s0         = stat_q[0];
    assign bus.ad_oe      = ad_oe_q;
    assign bus.bus_oe     = bus_oe_q;
    assign bus.hlda       = hlda_q;
    assign bus.a_hi       = a_hi_q;
    assign bus.ad_out     = ad_out_q;
    assign bus.rdata      = rdata_q;
    assign bus.cycle_done = cycle_done_q;

endmodule

// File: tb/tb_bus_cycle_seq.sv
// tb/tb_bus_cycle_seq.sv - scoreboard bench for bus_cycle_seq

module tb_bus_cycle_seq;

    logic phi1;
    logic reset;

    bus_cycle_seq_if bus_if ();

    bus_cycle_seq u_dut (
        .phi1  (phi1),
        .reset (reset),
        .bus   (bus_if)
    );

    initial begin
        phi1 = 1'b0;
        forever #5 phi1 = ~phi1;
    end

    typedef struct {
        logic [2:0] tstate;
        logic       req_ack;
        logic       cycle_done;
        logic [9:0] ctrl;
        logic [7:0] rdata;
        logic       chk_ahi;
        logic [7:0] a_hi;
        logic       chk_adout;
        logic [7:0] ad_out;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Requester intent for the coming edge.
    logic        drv_req = 1'b0;
    logic [2:0]  drv_type = 3'd0;
    logic [15:0] drv_addr = 16'h0;
    logic [7:0]  drv_wdata = 8'h0;
    logic [7:0]  drv_din = 8'h0;
    int          drv_waits = 0;
    logic        drv_hold = 1'b0;
    logic        drv_reset = 1'b1;

    // Reference model: current T-state code and the transaction in flight.
    logic [2:0]  m_cur = 3'd0;
    logic [2:0]  m_type = 3'd0;
    logic [15:0] m_addr = 16'h0;
    logic [7:0]  m_wdata = 8'h0;
    logic [7:0]  m_din = 8'h0;
    logic [7:0]  m_rdata = 8'h0;
    int          m_waits = 0;

    function automatic logic [2:0] status_tbl(input logic [2:0] t);
        logic [2:0] tbl [0:5];
        tbl[0] = 3'b011; tbl[1] = 3'b010; tbl[2] = 3'b001;
        tbl[3] = 3'b110; tbl[4] = 3'b101; tbl[5] = 3'b111;
        return (t <= 3'd5) ? tbl[t] : 3'b000;
    endfunction

    // One phi1 cycle: drive inputs, push expectations, advance the model.
    task automatic step(output bit acc);
        exp_t e;
        bit   long_c, fin, mid, inbus, rdlike, wrlike, pick;
        logic [2:0] nxt;
        @(negedge phi1);
        reset               = drv_reset;
        bus_if.hold         = drv_hold;
        bus_if.cycle_req    = drv_req;
        bus_if.cycle_type   = drv_type;
        bus_if.addr         = drv_addr;
        bus_if.wdata        = drv_wdata;
        bus_if.ad_in        = m_din;
        bus_if.ready        = !(((m_cur == 3'd2) || (m_cur == 3'd5)) && (m_waits > 0));

        long_c = (m_type == 3'd0) || (m_type == 3'd5);
        rdlike = (m_type == 3'd0) || (m_type == 3'd1) || (m_type == 3'd3);
        wrlike = (m_type == 3'd2) || (m_type == 3'd4);
        fin    = ((m_cur == 3'd3) && !long_c) || (m_cur == 3'd4);
        mid    = (m_cur == 3'd2) || (m_cur == 3'd3) || (m_cur == 3'd5);
        inbus  = (m_cur >= 3'd1) && (m_cur <= 3'd5);
        acc    = !drv_reset && drv_req && (drv_type <= 3'd5) && !drv_hold &&
                 ((m_cur == 3'd0) || fin);

        e.tstate     = m_cur;
        e.req_ack    = acc;
        e.cycle_done = fin;
        // {ale, rd_n, wr_n, inta_n, io_m, s1, s0, ad_oe, bus_oe, hlda}
        e.ctrl = {m_cur == 3'd1, !(mid && rdlike), !(mid && wrlike),
                  !(mid && m_type == 3'd5),
                  inbus ? status_tbl(m_type) : 3'b000,
                  (m_cur == 3'd1) || (mid && wrlike), m_cur != 3'd6, m_cur == 3'd6};
        e.rdata     = m_rdata;
        e.chk_ahi   = inbus;
        e.a_hi      = m_addr[15:8];
        e.chk_adout = (m_cur == 3'd1) || (mid && wrlike);
        e.ad_out    = (m_cur == 3'd1) ? m_addr[7:0] : m_wdata;
        exp_q.push_back(e);

        if (drv_reset) begin
            m_cur   = 3'd0;
            m_rdata = 8'h00;
            m_waits = 0;
        end else begin
            if ((m_cur == 3'd3) && (rdlike || m_type == 3'd5)) m_rdata = m_din;
            pick = 1'b0;
            nxt  = 3'd0;
            case (m_cur)
                3'd1: nxt = 3'd2;
                3'd2, 3'd5: begin
`ifdef BUS_WAIT_STATE_EN
                    if (m_waits > 0) begin
                        m_waits = m_waits - 1;
                        nxt = 3'd5;
                    end else nxt = 3'd3;
`else
                    nxt = 3'd3;
`endif
                end
                3'd3: if (long_c) nxt = 3'd4; else pick = 1'b1;
                3'd6: nxt = drv_hold ? 3'd6 : 3'd0;
                default: pick = 1'b1;
            endcase
            if (pick) nxt = drv_hold ? 3'd6 : (acc ? 3'd1 : 3'd0);
            if (acc) begin
                m_type  = drv_type;
                m_addr  = drv_addr;
                m_wdata = drv_wdata;
                m_din   = drv_din;
                m_waits = drv_waits;
            end
            m_cur = nxt;
        end
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    // Present a request and keep it up until the model accepts it
    // (reserved types are only presented for a few cycles).
    task automatic issue(input logic [2:0] t, input logic [15:0] a, input logic [7:0] w,
                         input int waits, input logic [7:0] din);
        bit acc;
        drv_req = 1'b1; drv_type = t; drv_addr = a; drv_wdata = w;
        drv_waits = waits; drv_din = din;
        for (int i = 0; i < ((t >= 3'd6) ? 3 : 60); i++) begin
            step(acc);
            if (acc) break;
        end
    endtask

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp_v);
        end
    endtask

    // Monitor: compares every presented cycle against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge phi1);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("tstate", {13'd0, bus_if.tstate}, {13'd0, e.tstate});
                chk("req_ack", {15'd0, bus_if.req_ack}, {15'd0, e.req_ack});
                chk("cycle_done", {15'd0, bus_if.cycle_done}, {15'd0, e.cycle_done});
                chk("ctrl", {6'd0, bus_if.ale, bus_if.rd_n, bus_if.wr_n, bus_if.inta_n,
                             bus_if.io_m, bus_if.s1, bus_if.s0, bus_if.ad_oe,
                             bus_if.bus_oe, bus_if.hlda}, {6'd0, e.ctrl});
                chk("rdata", {8'd0, bus_if.rdata}, {8'd0, e.rdata});
                if (e.chk_ahi) chk("a_hi", {8'd0, bus_if.a_hi}, {8'd0, e.a_hi});
                if (e.chk_adout) chk("ad_out", {8'd0, bus_if.ad_out}, {8'd0, e.ad_out});
            end
        end
    end

    initial begin
        logic [2:0] t;
        int gap;
        reset = 1'b1;
        bus_if.cycle_req = 1'b0; bus_if.cycle_type = 3'd0; bus_if.addr = 16'h0;
        bus_if.wdata = 8'h0; bus_if.ad_in = 8'h0; bus_if.ready = 1'b1; bus_if.hold = 1'b0;
        repeat (2) @(posedge phi1);

        // reset state, with hold and a request asserted to show reset wins
        drv_reset = 1'b1; drv_hold = 1'b1; drv_req = 1'b1;
        idle(2);
        drv_reset = 1'b0; drv_hold = 1'b0; drv_req = 1'b0;
        idle(2);

        // memory read 2050 -> A5
        issue(3'd1, 16'h2050, 8'h00, 0, 8'hA5);
        drv_req = 1'b0; idle(5);

        // opcode fetch with two wait cycles
        issue(3'd0, 16'h0000, 8'h00, 2, 8'h7E);
        drv_req = 1'b0; idle(8);

        // IO write followed back-to-back by memory write
        issue(3'd4, 16'h0042, 8'h3C, 0, 8'h00);
        issue(3'd2, 16'h1234, 8'hC3, 0, 8'h00);
        drv_req = 1'b0; idle(5);

        // hold raised during memory read T2
        issue(3'd1, 16'h4001, 8'h00, 0, 8'h5A);
        drv_req = 1'b0; idle(1);
        drv_hold = 1'b1; idle(4);
        drv_hold = 1'b0; idle(3);

        // reset in the middle of a write with waits, then reserved type
        issue(3'd2, 16'h8080, 8'h99, 3, 8'h00);
        drv_req = 1'b0; idle(2);
        drv_reset = 1'b1; idle(1);
        drv_reset = 1'b0; idle(2);
        issue(3'd7, 16'hFFFF, 8'h11, 0, 8'h00);
        drv_req = 1'b0; idle(2);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            t = 3'($urandom_range(0, 7));
            issue(t, 16'($urandom), 8'($urandom), $urandom_range(0, 3), 8'($urandom));
            gap = $urandom_range(0, 3);
            if (gap > 0) begin
                drv_req  = 1'b0;
                drv_hold = ($urandom_range(0, 4) == 0);
                idle(gap);
                drv_hold = 1'b0;
            end
        end
        drv_req = 1'b0;
        idle(8);

        @(negedge phi1);
        #5;
        chk("scoreboard_drained", 16'(exp_q.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bus_cycle_seq.md
BUS_CYCLE_SEQ -- requirements
Module: bus_cycle_seq

Interface
REQ-001 SHALL have ports: phi1 input 1 (sole clock, rising edge); reset input 1 (synchronous, active-high).
REQ-002 SHALL have inputs: cycle_req 1 (cycle request); cycle_type 3 (0 opcode fetch, 1 mem read, 2 mem write, 3 IO read, 4 IO write, 5 INTA, 6/7 reserved); addr 16; wdata 8; ad_in 8 (AD bus read data); ready 1 (slave ready); hold 1 (DMA bus request).
REQ-003 SHALL have outputs: req_ack 1 (request accepted); a_hi 8 (A15..A8); ad_out 8 (AD7..AD0 drive value); ad_oe 1 (AD drive enable); bus_oe 1 (address/control drive enable); ale 1; rd_n 1; wr_n 1; inta_n 1; io_m 1; s1 1; s0 1; rdata 8 (captured read data); cycle_done 1 (final T-state flag); hlda 1; tstate 3 (0 TI, 1 T1, 2 T2, 3 T3, 4 T4, 5 TW, 6 THOLD).

Function
REQ-004 SHALL implement states TI, T1, T2, TW, T3, T4, THOLD; one state per phi1 cycle.
REQ-005 SHALL accept a request (req_ack=1 for that cycle; latch cycle_type, addr, wdata) when cycle_req=1, type 0..5, hold=0, and state is TI or the final T-state; next state T1.
REQ-006 SHALL ignore reserved types 6/7: no req_ack, state unchanged.
REQ-007 T1: ale=1, a_hi=addr[15:8], ad_out=addr[7:0], ad_oe=1, io_m/s1/s0 per REQ-008, held through the whole cycle.
REQ-008 Status (io_m,s1,s0): fetch 0,1,1; mem read 0,1,0; mem write 0,0,1; IO read 1,1,0; IO write 1,0,1; INTA 1,1,1; TI/THOLD 0,0,0.
REQ-009 T2/TW/T3 reads (types 0,1,3): rd_n=0, ad_oe=0; INTA uses inta_n=0 instead of rd_n.
REQ-010 T2/TW/T3 writes (types 2,4): wr_n=0, ad_out=wdata, ad_oe=1.
REQ-011 In T2 and TW, ready=0 SHALL give next state TW; ready=1 gives T3; no wait limit.
REQ-012 rdata SHALL load ad_in at the edge leaving T3 for read/INTA types and hold until next capture.
REQ-013 Fetch and INTA SHALL continue T3->T4 (strobes inactive, ad_oe=0); other types end at T3.
REQ-014 cycle_done=1 exactly during final T-state (T3, or T4 for fetch/INTA).
REQ-015 From final T-state: hold=1 -> THOLD; else accepted request -> T1; else TI. From TI: hold=1 -> THOLD (hold beats cycle_req).
REQ-016 THOLD: hlda=1, bus_oe=0, ad_oe=0, strobes inactive; hold=0 -> TI with hlda=0 next cycle.
REQ-017 bus_oe=1 in all states except THOLD.

Reset
REQ-018 reset=1 at an edge SHALL force state TI, aborting any cycle, with ale=0, rd_n=wr_n=inta_n=1, io_m=s1=s0=0, ad_oe=0, bus_oe=1, a_hi=ad_out=rdata=0, req_ack=cycle_done=hlda=0, tstate=0.
REQ-019 reset SHALL override hold and cycle_req; no partial rdata capture.

Configuration
REQ-020 Macro BUS_WAIT_STATE_EN defined: ready honoured per REQ-011. Undefined: ready ignored, T2 always -> T3, TW unreachable.

Verification
REQ-021 Mem read addr=16'h2050, ad_in=8'hA5, ready=1 -> T1,T2,T3; ale=1 only in T1; a_hi=8'h20; rd_n=0 T2-T3; rdata=8'hA5; cycle_done in T3.
REQ-022 Fetch addr=16'h0000 with ready=0 for 2 cycles -> T1,T2,TW,TW,T3,T4; status 0,1,1; cycle_done in T4 (macro undefined: T1,T2,T3,T4).
REQ-023 IO write addr=16'h0042, wdata=8'h3C, back-to-back mem write -> T1,T2,T3,T1...; wr_n=0 T2-T3; ad_out=8'h3C, io_m=1; second req_ack during first T3.
REQ-024 hold=1 raised in mem-read T2 -> cycle completes, THOLD, hlda=1, bus_oe=0; hold=0 -> TI, hlda=0 next cycle.
REQ-025 reset=1 during write TW -> next edge TI, wr_n=1, all REQ-018 values; cycle_type=7 request -> no req_ack, stays TI.
